// File: rtl/msrv32_dmem_access_ctrl.sv
// msrv32 data-memory access sequencer: accepts one load/store,
// drives the AHB-style data port and hands the captured word to the load unit.
module msrv32_dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  input  logic        req_store_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        req_ready_out,
  output logic        stall_out,
  output logic        done_out,
  output logic        err_out,
  output logic        misaligned_out,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dm_valid_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_hready_in,
  input  logic        ahb_resp_in,
  output logic [31:0] lu_rdata_out,
  output logic [1:0]  lu_addr_1_to_0_out,
  output logic [1:0]  lu_size_out,
  output logic        lu_unsigned_out,
  output logic        lu_ahb_resp_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_next;

  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic        r_store;
  logic [31:0] r_rdata;
  logic [1:0]  r_lsb;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic        r_resp;

  logic        w_byte;
  logic        w_half;
  logic        w_word;
  logic        w_misal;
  logic        w_accept;
  logic        w_timeout;
  logic        w_bus;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;

  assign w_byte = (req_size_in == 2'b00);
  assign w_half = (req_size_in == 2'b01);
  assign w_word = req_size_in[1];

  assign w_misal = (w_half & req_addr_in[0])
                 | (w_word & (|req_addr_in[1:0]));

  assign w_accept  = (r_state == S_IDLE) & req_valid_in & ~w_misal;
  assign w_timeout = (r_cnt == LP_TO_LAST);
  assign w_bus     = (r_state == S_ADDR) | (r_state == S_DATA);

  // Byte lanes and lane-replicated store data from the request size.
  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = req_wdata_in;
    unique case (1'b1)
      w_word: begin
        w_mask  = 4'b1111;
        w_wdata = req_wdata_in;
      end
      w_half: begin
        w_mask  = 4'b0011 << {req_addr_in[1], 1'b0};
        w_wdata = {2{req_wdata_in[15:0]}};
      end
      w_byte: begin
        w_mask  = 4'b0001 << req_addr_in[1:0];
        w_wdata = {4{req_wdata_in[7:0]}};
      end
      default: begin
        w_mask  = 4'b0000;
        w_wdata = req_wdata_in;
      end
    endcase
    if (!req_store_in) begin
      w_mask = 4'b0000;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_ADDR;
        end
      end
      S_ADDR: begin
        w_next = S_DATA;
      end
      S_DATA: begin
        if (ms_riscv32_mp_hready_in || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_ADDR) begin
      r_cnt <= 8'd0;
    end else if ((r_state == S_DATA) && !ms_riscv32_mp_hready_in) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Request fields are latched only on acceptance and held until the next one.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_addr     <= 32'd0;
      r_mask     <= 4'd0;
      r_wdata    <= 32'd0;
      r_store    <= 1'b0;
      r_lsb      <= 2'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= {req_addr_in[31:2], 2'b00};
      r_mask     <= w_mask;
      r_wdata    <= w_wdata;
      r_store    <= req_store_in;
      r_lsb      <= req_addr_in[1:0];
      r_size     <= req_size_in;
      r_unsigned <= req_unsigned_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_rdata <= 32'd0;
      r_resp  <= 1'b0;
    end else if (w_accept) begin
      r_resp <= 1'b0;
    end else if (r_state == S_DATA) begin
      if (ms_riscv32_mp_hready_in) begin
        r_resp <= ahb_resp_in;
        if (!r_store) begin
          r_rdata <= ms_riscv32_mp_dmdata_in;
        end
      end else if (w_timeout) begin
        r_resp <= 1'b1;
      end
    end
  end

  assign req_ready_out  = (r_state == S_IDLE);
  assign stall_out      = w_accept | w_bus;
  assign done_out       = (r_state == S_DONE);
  assign err_out        = (r_state == S_DONE) & r_resp;
  assign misaligned_out = (r_state == S_IDLE) & req_valid_in & w_misal;

  assign ms_riscv32_mp_dmaddr_out    = r_addr;
  assign ms_riscv32_mp_dm_valid_out  = w_bus;
  assign ms_riscv32_mp_dmwr_req_out  = w_bus & r_store;
  assign ms_riscv32_mp_dmwr_mask_out = r_mask;
  assign ms_riscv32_mp_dmdata_out    = r_wdata;

  assign lu_rdata_out       = r_rdata;
  assign lu_addr_1_to_0_out = r_lsb;
  assign lu_size_out        = r_size;
  assign lu_unsigned_out    = r_unsigned;
  assign lu_ahb_resp_out    = r_resp;

endmodule
